// File: rtl/hex_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot blanking gap.
// Optional leading-zero blanking when HEX_SCAN_LZB_EN is defined.
module hex_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic                  i_load,
  output logic [3:0]            o_hex,
  output logic [DIGITS-1:0]     o_digit_en,
  output logic                  o_frame
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VW-1:0]   shadow_q, shadow_d;
  logic [VW-1:0]   disp_q, disp_d;
  logic [3:0]      hex_d;
  logic [DIGITS-1:0] en_d;
  logic            frame_d;
  logic            wrap;
  logic            boundary;
  logic            lit;
`ifdef HEX_SCAN_LZB_EN
  logic [IW-1:0]   msd_q, msd_d;
`endif

  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    boundary = wrap && (idx_q == IDX_MAX);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (wrap)
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    shadow_d = i_load ? i_value : shadow_q;
    disp_d   = disp_q;
    // a load on the boundary cycle bypasses the shadow so it is not lost
    if (boundary)
      disp_d = i_load ? i_value : shadow_q;

    state_d = state_q;
    unique case (state_q)
      S_BLANK: if (cnt_q == CNT_LAST) state_d = S_ON;
      S_ON:    if (wrap) state_d = S_BLANK;
    endcase

`ifdef HEX_SCAN_LZB_EN
    msd_d = msd_q;
    if (boundary) begin
      msd_d = '0;
      for (int k = 0; k < DIGITS; k++)
        if (disp_d[4*k +: 4] != 4'h0) msd_d = IW'(k);
    end
    lit = (idx_d <= msd_d);
`else
    lit = 1'b1;
`endif

    hex_d   = disp_d[{idx_d, 2'b00} +: 4];
    en_d    = (state_d == S_ON && lit) ? ~(DIGITS'(1) << idx_d) : '1;
    frame_d = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      disp_q     <= '0;
      o_hex      <= 4'h0;
      o_digit_en <= '1;
      o_frame    <= 1'b0;
`ifdef HEX_SCAN_LZB_EN
      msd_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      disp_q     <= disp_d;
      o_hex      <= hex_d;
      o_digit_en <= en_d;
      o_frame    <= frame_d;
`ifdef HEX_SCAN_LZB_EN
      msd_q      <= msd_d;
`endif
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: constant vector table, directed sequences
// and random traffic against a cycle-count based reference model.
module tb_hex_scan_driver;

  localparam int D = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_load = 1'b0;
  logic [15:0] i_value = 16'h0;
  logic [3:0]  o_hex;
  logic [3:0]  o_digit_en;
  logic        o_frame;

  int n_cmp = 0;
  int n_bad = 0;

  int          t;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;

  always #5 clk = ~clk;

  hex_scan_driver #(
    .DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_value(i_value),
    .i_load(i_load), .o_hex(o_hex),
    .o_digit_en(o_digit_en), .o_frame(o_frame)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic [15:0] val;
    logic [3:0] en;
    logic [3:0] hex;
    logic       fr;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic int msd_of(input logic [15:0] v);
    int m = 0;
    for (int k = 0; k < D; k++)
      if (((v >> (4*k)) & 16'hF) != 0) m = k;
    return m;
  endfunction

  task automatic model_check();
    int idx;
    int slot;
    logic [3:0] e_en;
    logic [3:0] e_hex;
    logic       e_fr;
    idx   = (t / P) % D;
    slot  = t % P;
    e_hex = 4'((m_disp >> (4*idx)) & 16'hF);
    e_en  = (slot < B) ? 4'hF : ~(4'b0001 << idx);
`ifdef HEX_SCAN_LZB_EN
    if (idx > msd_of(m_disp)) e_en = 4'hF;
`endif
    e_fr = (slot == P-1) && (idx == D-1);
    chk("model_en", {12'h0, o_digit_en}, {12'h0, e_en});
    chk("model_hex", {12'h0, o_hex}, {12'h0, e_hex});
    chk("model_frame", {15'h0, o_frame}, {15'h0, e_fr});
  endtask

  task automatic step(input logic rst, input logic ld,
                      input logic [15:0] v);
    i_rst = rst;
    i_load = ld;
    i_value = v;
    @(posedge clk);
    if (rst) begin
      t = 0;
      m_shadow = 16'h0;
      m_disp = 16'h0;
    end else begin
      if (t % P == P-1 && (t / P) % D == D-1)
        m_disp = ld ? v : m_shadow;
      if (ld) m_shadow = v;
      t++;
    end
    #1;
    i_rst = 1'b0;
    i_load = 1'b0;
    model_check();
  endtask

  task automatic run_to(input int target);
    while (t < target) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic chk_out(input string name, input logic [3:0] en,
                         input logic [3:0] hex);
    chk({name, "_en"}, {12'h0, o_digit_en}, {12'h0, en});
    chk({name, "_hex"}, {12'h0, o_hex}, {12'h0, hex});
  endtask

  logic [3:0] seq_a[4];
  logic [3:0] seq_b[4];
  logic [3:0] seq_c[4];
  logic [3:0] lzb_en;

  initial begin
    t = 0;
    m_shadow = 16'h0;
    m_disp = 16'h0;

    for (int i = 0; i < 3; i++)
      tbl[i] = '{1'b1, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0};
    for (int c = 1; c < 16; c++) begin
      tbl[c+2] = '{1'b0, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0};
      if (c >= 2 && c <= 7) tbl[c+2].en = 4'b1110;
`ifndef HEX_SCAN_LZB_EN
      if (c >= 10) tbl[c+2].en = 4'b1101;
`endif
    end

    seq_a = '{4'hF, 4'h2, 4'hA, 4'h4};
    seq_b = '{4'h4, 4'h3, 4'h2, 4'h1};
    seq_c = '{4'hF, 4'hE, 4'hE, 4'hB};

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].ld, tbl[i].val);
      chk("tbl_en", {12'h0, o_digit_en}, {12'h0, tbl[i].en});
      chk("tbl_hex", {12'h0, o_hex}, {12'h0, tbl[i].hex});
      chk("tbl_frame", {15'h0, o_frame}, {15'h0, tbl[i].fr});
    end

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h4A2F);
    run_to(31);
    chk("frame_at_31", {15'h0, o_frame}, 16'h1);
    chk("old_frame_hex", {12'h0, o_hex}, 16'h0);
    for (int d = 0; d < 4; d++) begin
      run_to(32 + 8*d + 3);
      chk_out("frame_a", ~(4'b0001 << d), seq_a[d]);
    end

    run_to(77);
    step(1'b0, 1'b1, 16'h1234);
    chk_out("tear_d1", 4'b1101, 4'h2);
    run_to(83);
    chk_out("tear_d2", 4'b1011, 4'hA);
    run_to(91);
    chk_out("tear_d3", 4'b0111, 4'h4);
    for (int d = 0; d < 4; d++) begin
      run_to(96 + 8*d + 3);
      chk_out("frame_b", ~(4'b0001 << d), seq_b[d]);
    end

    run_to(125);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 16'h0);
    chk("sim_frame", {15'h0, o_frame}, 16'h1);
    step(1'b0, 1'b1, 16'hBEEF);
    chk_out("sim_blank", 4'hF, 4'hF);
    for (int d = 0; d < 4; d++) begin
      run_to(128 + 8*d + 3);
      chk_out("frame_c", ~(4'b0001 << d), seq_c[d]);
    end

    run_to(147);
    step(1'b1, 1'b0, 16'h0);
    chk_out("midrst", 4'hF, 4'h0);
    chk("midrst_frame", {15'h0, o_frame}, 16'h0);
    run_to(3);
    chk_out("rst_restart", 4'b1110, 4'h0);

    step(1'b0, 1'b1, 16'h0030);
    for (int d = 0; d < 4; d++) begin
      run_to(32 + 8*d + 3);
      lzb_en = ~(4'b0001 << d);
`ifdef HEX_SCAN_LZB_EN
      if (d > 1) lzb_en = 4'hF;
`endif
      chk("lzb_en", {12'h0, o_digit_en}, {12'h0, lzb_en});
    end

    for (int i = 0; i < 2000; i++) begin
      logic [15:0] v;
      v = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
- Latches a packed hex value and presents one nibble at a time on o_hex, which feeds the downstream nibble-to-segment decoder.
- Drives active-low one-hot digit enables in step with o_hex.
- Inserts a blanking gap between digits to suppress ghosting.

Parameters:
- DIGITS, 4: number of digits scanned; i_value width is 4*DIGITS.
- PRESCALE, 50000: clock cycles per digit slot, blank phase included; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits off; must be at least 1.

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_value  input  4*DIGITS  packed hex value; nibble k is digit k, and digit 0 is the least significant.
- i_load  input  1  one-cycle strobe; captures i_value into the shadow register.
- o_hex  output  4  nibble for the current digit, to the segment decoder.
- o_digit_en  output  DIGITS  active-low one-hot digit enables; all ones means all digits off.
- o_frame  output  1  one-cycle pulse marking the end of a full scan frame.

Behaviour:
- Reset (i_rst high at a clock edge) sets:
  - shadow and display registers to 0
  - digit index to 0, slot counter to 0, state to S_BLANK
  - o_hex to 4'h0, o_digit_en to all ones, o_frame to 0
- Reset mid-scan aborts the slot immediately, with no partial completion.
- All outputs are registered and change only on clock edges.
- Slot counter runs 0..PRESCALE-1, then wraps to 0 and advances the digit index.
- S_BLANK:
  - Active while counter < BLANK_CYCLES.
  - o_digit_en is all ones.
  - o_hex already holds display[4*idx+3 : 4*idx].
- S_ON:
  - Active while counter >= BLANK_CYCLES.
  - o_digit_en bit idx is 0; all other bits are 1.
- Transitions:
  - S_BLANK to S_ON on the edge where the counter goes from BLANK_CYCLES-1 to BLANK_CYCLES.
  - S_ON to S_BLANK on the counter wrap. On that edge idx increments (DIGITS-1 wraps to 0) and o_hex is reloaded for the new idx.
- Frame boundary is the cycle with counter == PRESCALE-1 and idx == DIGITS-1.
  - o_frame is high for exactly that one cycle.
  - On the following edge, display is loaded from shadow, so a digit never shows a mix of old and new values within a frame.
- Load rules:
  - i_load high: shadow <= i_value on the next edge.
  - i_load coinciding with the frame boundary: display <= i_value directly, so the new value wins.
  - Back-to-back loads: the last one before the boundary wins.
- Scan timing:
  - Frame period is DIGITS*PRESCALE cycles.
  - After reset release, digit 0 is enabled from cycle BLANK_CYCLES through PRESCALE-1.
- o_hex keeps its value through S_BLANK and S_ON of the same slot.

Optional Feature:
- Macro: HEX_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - At the frame boundary, compute the index of the highest nonzero nibble of the value being loaded into display, giving msd (0 if the value is 0).
  - Digit slots with idx > msd keep o_digit_en all ones in S_ON.
  - Digit 0 is always shown.
  - Slot timing and o_frame are unchanged.
- Undefined: every digit is enabled in its S_ON phase regardless of value.

Test Plan (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
- Reset sequencing: hold i_rst for 3 cycles, then release.
  - o_digit_en=4'b1111 and o_hex=0 during reset.
  - Cycles 0-1 after release: 4'b1111.
  - Cycles 2-7: 4'b1110.
  - Cycles 8-9: 4'b1111.
  - Cycles 10-15: 4'b1101.
- Frame timing: i_load with i_value=16'h4A2F at cycle 0.
  - o_frame pulses at cycle 31.
  - Next frame shows o_hex sequence F, 2, A, 4 on digits 0-3.
  - The current frame still shows 0.
- Tearing guard: load 16'h1234 mid-frame (cycle 13).
  - Digits 1-3 of the current frame still show the old nibbles.
  - The new value appears only after o_frame.
- Simultaneous load and frame: i_load=1 with 16'hBEEF on the o_frame cycle.
  - Next frame displays F, E, E, B.
  - A load of 16'h0000 two cycles earlier is overridden.
- Reset mid-scan: assert i_rst in digit 2's S_ON phase.
  - Next edge gives o_digit_en=4'b1111 and o_hex=0.
  - Sequencing restarts at digit 0 with the display value 0.
- HEX_SCAN_LZB_EN defined: load 16'h0030.
  - Digits 2-3 stay at 4'b1111 in S_ON; digits 0-1 are enabled.
  - With value 0, only digit 0 is enabled.
